// File: rtl/instruction_decode_stage_if.sv
// Fetch/decode/execute boundary of the decode stage: the fetch control loop back to
// program memory plus the ID/EX pipeline register contents.
interface instruction_decode_stage_if;
  logic [31:0] ins;
  logic [15:0] current_address;
  logic        stall;
  logic        stall_pm;
  logic        pc_mux_sel;
  logic [15:0] jmp_loc;
  logic        ex_valid;
  logic [2:0]  ex_class;
  logic [3:0]  ex_func;
  logic [4:0]  ex_rd;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [15:0] ex_imm;
  logic [15:0] ex_pc;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        illegal;
  logic        halted;

  // Instruction source side (program memory / testbench).
  modport master (
    output ins, current_address,
    input  stall, stall_pm, pc_mux_sel, jmp_loc,
    input  ex_valid, ex_class, ex_func, ex_rd, ex_rs, ex_rt, ex_imm, ex_pc,
    input  ex_reg_write, ex_mem_read, ex_mem_write, illegal, halted
  );

  // Decode stage side.
  modport slave (
    input  ins, current_address,
    output stall, stall_pm, pc_mux_sel, jmp_loc,
    output ex_valid, ex_class, ex_func, ex_rd, ex_rs, ex_rt, ex_imm, ex_pc,
    output ex_reg_write, ex_mem_read, ex_mem_write, illegal, halted
  );
endinterface

// File: rtl/instruction_decode_stage.sv
// Decodes ins into the ID/EX register (1-cycle latency); stalls on load-use and HALT,
// redirects fetch on JMP and squashes the following wrong-path slot.
module instruction_decode_stage (
  input logic                          clk,
  input logic                          reset,
  instruction_decode_stage_if.slave    bus
);

  typedef enum logic [1:0] {ST_RUN, ST_SQUASH, ST_HALT} state_t;

  typedef struct packed {
    logic        valid;
    logic [2:0]  cls;
    logic [3:0]  func;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic [15:0] pc;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } ex_t;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ALUR = 6'h01;
  localparam logic [5:0] OP_ALUI = 6'h02;
  localparam logic [5:0] OP_LOAD = 6'h03;
  localparam logic [5:0] OP_STOR = 6'h04;
  localparam logic [5:0] OP_JMP  = 6'h05;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [2:0] CLS_NOP  = 3'd0;
  localparam logic [2:0] CLS_ALUR = 3'd1;
  localparam logic [2:0] CLS_ALUI = 3'd2;
  localparam logic [2:0] CLS_LOAD = 3'd3;
  localparam logic [2:0] CLS_STOR = 3'd4;

  state_t      state_q, state_d;
  ex_t         ex_q, ex_d;
  logic [15:0] dec_pc_q;
  logic        illegal_q;

  logic [5:0]  opcode;
  logic [4:0]  f_rd, f_rs, f_rt;
  logic [15:0] f_imm;
  logic        reads_rs, reads_rt, known_op;
  logic [2:0]  dec_cls;
  logic        load_use;
  logic        stall_c, jump_c, illegal_set;

  assign opcode = bus.ins[31:26];
  assign f_rd   = bus.ins[25:21];
  assign f_rs   = bus.ins[20:16];
  assign f_rt   = bus.ins[15:11];
  assign f_imm  = bus.ins[15:0];

  always_comb begin
    reads_rs = 1'b0;
    reads_rt = 1'b0;
    known_op = 1'b1;
    dec_cls  = CLS_NOP;
    case (opcode)
      OP_NOP:  ;
      OP_ALUR: begin reads_rs = 1'b1; reads_rt = 1'b1; dec_cls = CLS_ALUR; end
      OP_ALUI: begin reads_rs = 1'b1; dec_cls = CLS_ALUI; end
      OP_LOAD: begin reads_rs = 1'b1; dec_cls = CLS_LOAD; end
      OP_STOR: begin reads_rs = 1'b1; reads_rt = 1'b1; dec_cls = CLS_STOR; end
      OP_JMP:  ;
      OP_HALT: ;
      default: known_op = 1'b0;
    endcase
  end

  // r0 is never a real producer, so a LOAD targeting it cannot create a hazard.
  assign load_use = (state_q == ST_RUN) && ex_q.valid && (ex_q.cls == CLS_LOAD) &&
                    (ex_q.rd != 5'd0) &&
                    ((reads_rs && (f_rs == ex_q.rd)) || (reads_rt && (f_rt == ex_q.rd)));

  always_comb begin
    state_d     = state_q;
    ex_d        = '0;
    stall_c     = 1'b0;
    jump_c      = 1'b0;
    illegal_set = 1'b0;
    case (state_q)
      ST_SQUASH: state_d = ST_RUN;
      ST_HALT:   stall_c = 1'b1;
      default: begin
        if (load_use) begin
          stall_c = 1'b1;
        end else if (opcode == OP_JMP) begin
          jump_c  = 1'b1;
          state_d = ST_SQUASH;
        end else if (opcode == OP_HALT) begin
          state_d = ST_HALT;
        end else begin
          ex_d.valid     = 1'b1;
          ex_d.cls       = dec_cls;
          ex_d.func      = bus.ins[3:0];
          ex_d.rd        = f_rd;
          ex_d.rs        = f_rs;
          ex_d.rt        = f_rt;
          ex_d.imm       = f_imm;
          ex_d.pc        = dec_pc_q;
          ex_d.reg_write = (dec_cls == CLS_ALUR) || (dec_cls == CLS_ALUI) || (dec_cls == CLS_LOAD);
          ex_d.mem_read  = (dec_cls == CLS_LOAD);
          ex_d.mem_write = (dec_cls == CLS_STOR);
          illegal_set    = !known_op;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      ex_q      <= '0;
      dec_pc_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      if (!stall_c)
        dec_pc_q <= bus.current_address;
      if (illegal_set)
        illegal_q <= 1'b1;
    end
  end

  // Fetch controls are combinational from ins, so they are forced low while reset is held.
  assign bus.stall      = reset & stall_c;
  assign bus.stall_pm   = reset & stall_c;
  assign bus.pc_mux_sel = reset & jump_c;
  assign bus.jmp_loc    = (reset & jump_c) ? f_imm : 16'h0000;

  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_class     = ex_q.cls;
  assign bus.ex_func      = ex_q.func;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_rs        = ex_q.rs;
  assign bus.ex_rt        = ex_q.rt;
  assign bus.ex_imm       = ex_q.imm;
  assign bus.ex_pc        = ex_q.pc;
  assign bus.ex_reg_write = ex_q.reg_write;
  assign bus.ex_mem_read  = ex_q.mem_read;
  assign bus.ex_mem_write = ex_q.mem_write;
  assign bus.illegal      = illegal_q;
  assign bus.halted       = (state_q == ST_HALT);

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed bench for instruction_decode_stage: inputs change 1 time unit after each
// rising edge, combinational outputs are sampled 1 unit later, registers after the edge.
module tb_instruction_decode_stage;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  instruction_decode_stage_if bus ();

  instruction_decode_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [15:0] imm);
    enc = {op, rd, rs, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [3:0] func);
    enc_r = {op, rd, rs, rt, 7'd0, func};
  endfunction

  task automatic drive(input logic [31:0] i, input logic [15:0] a);
    bus.ins             = i;
    bus.current_address = a;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset               = 1'b0;
    bus.ins             = 32'h0;
    bus.current_address = 16'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset               = 1'b0;
    bus.ins             = enc(6'h05, 5'd0, 5'd0, 16'h1234);
    bus.current_address = 16'h0055;
    #3;
    checks++; if (bus.pc_mux_sel !== 1'b0) begin errors++; $display("FAIL reset_pc_mux_sel: got %0h want 0", bus.pc_mux_sel); end
    checks++; if (bus.jmp_loc !== 16'h0) begin errors++; $display("FAIL reset_jmp_loc: got %0h want 0", bus.jmp_loc); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0h want 0", bus.stall); end
    tick();
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %0h want 0", bus.ex_valid); end
    checks++; if (bus.ex_pc !== 16'h0) begin errors++; $display("FAIL reset_ex_pc: got %0h want 0", bus.ex_pc); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0h want 0", bus.halted); end
    checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %0h want 0", bus.illegal); end
    reset = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] prog [4];
    logic [2:0]  cls_exp [4];
    prog[0] = 32'h0;                                   cls_exp[0] = 3'd0;
    prog[1] = enc_r(6'h01, 5'd1, 5'd2, 5'd3, 4'h4);    cls_exp[1] = 3'd1;
    prog[2] = enc(6'h02, 5'd4, 5'd1, 16'h0010);        cls_exp[2] = 3'd2;
    prog[3] = enc_r(6'h04, 5'd0, 5'd1, 5'd2, 4'h0);    cls_exp[3] = 3'd4;
    do_reset();
    for (int a = 0; a < 4; a++) begin
      drive(prog[a], 16'(a + 1));
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL stream_stall[%0d]: got %0h want 0", a, bus.stall); end
      tick();
      checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %0h want 1", a, bus.ex_valid); end
      checks++; if (bus.ex_pc !== 16'(a)) begin errors++; $display("FAIL stream_pc[%0d]: got %0h want %0h", a, bus.ex_pc, a); end
      checks++; if (bus.ex_class !== cls_exp[a]) begin errors++; $display("FAIL stream_class[%0d]: got %0h want %0h", a, bus.ex_class, cls_exp[a]); end
    end
    checks++; if (bus.ex_mem_write !== 1'b1) begin errors++; $display("FAIL stream_store_memwr: got %0h want 1", bus.ex_mem_write); end
    checks++; if (bus.ex_rt !== 5'd2) begin errors++; $display("FAIL stream_store_rt: got %0h want 2", bus.ex_rt); end
  endtask

  task automatic test_load_use();
    logic [31:0] alu;
    alu = enc_r(6'h01, 5'd6, 5'd5, 5'd2, 4'h0);
    do_reset();
    drive(enc(6'h03, 5'd5, 5'd1, 16'h0008), 16'h0001);
    tick();
    checks++; if (bus.ex_mem_read !== 1'b1) begin errors++; $display("FAIL lu_load_memrd: got %0h want 1", bus.ex_mem_read); end
    checks++; if (bus.ex_rd !== 5'd5) begin errors++; $display("FAIL lu_load_rd: got %0h want 5", bus.ex_rd); end
    drive(alu, 16'h0002);
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %0h want 1", bus.stall); end
    checks++; if (bus.stall_pm !== 1'b1) begin errors++; $display("FAIL lu_stall_pm: got %0h want 1", bus.stall_pm); end
    tick();
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble_valid: got %0h want 0", bus.ex_valid); end
    checks++; if (bus.ex_rd !== 5'd0) begin errors++; $display("FAIL lu_bubble_rd: got %0h want 0", bus.ex_rd); end
    drive(alu, 16'h0002);
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_restall: got %0h want 0", bus.stall); end
    tick();
    checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL lu_issue_valid: got %0h want 1", bus.ex_valid); end
    checks++; if (bus.ex_rs !== 5'd5) begin errors++; $display("FAIL lu_issue_rs: got %0h want 5", bus.ex_rs); end
    checks++; if (bus.ex_pc !== 16'h0001) begin errors++; $display("FAIL lu_issue_pc: got %0h want 1", bus.ex_pc); end
    drive(enc(6'h03, 5'd0, 5'd1, 16'h0000), 16'h0003);
    tick();
    drive(enc_r(6'h01, 5'd6, 5'd0, 5'd0, 4'h0), 16'h0004);
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_r0_stall: got %0h want 0", bus.stall); end
    tick();
    checks++; if (bus.ex_pc !== 16'h0003) begin errors++; $display("FAIL lu_r0_pc: got %0h want 3", bus.ex_pc); end
  endtask

  task automatic test_jump();
    do_reset();
    for (int a = 0; a < 7; a++) begin
      drive(32'h0, 16'(a + 1));
      tick();
    end
    drive(enc(6'h05, 5'd0, 5'd0, 16'h0040), 16'h0008);
    checks++; if (bus.pc_mux_sel !== 1'b1) begin errors++; $display("FAIL jmp_sel: got %0h want 1", bus.pc_mux_sel); end
    checks++; if (bus.jmp_loc !== 16'h0040) begin errors++; $display("FAIL jmp_loc: got %0h want 40", bus.jmp_loc); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL jmp_stall: got %0h want 0", bus.stall); end
    tick();
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL jmp_bubble: got %0h want 0", bus.ex_valid); end
    drive(enc(6'h05, 5'd0, 5'd0, 16'h0099), 16'h0040);
    checks++; if (bus.pc_mux_sel !== 1'b0) begin errors++; $display("FAIL squash_sel: got %0h want 0", bus.pc_mux_sel); end
    tick();
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL squash_bubble: got %0h want 0", bus.ex_valid); end
    drive(enc(6'h02, 5'd3, 5'd1, 16'h0005), 16'h0041);
    tick();
    checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL jmp_target_valid: got %0h want 1", bus.ex_valid); end
    checks++; if (bus.ex_pc !== 16'h0040) begin errors++; $display("FAIL jmp_target_pc: got %0h want 40", bus.ex_pc); end
  endtask

  task automatic test_jmp_halt();
    do_reset();
    drive(enc(6'h05, 5'd0, 5'd0, 16'h0010), 16'h0001);
    tick();
    drive(enc(6'h3F, 5'd0, 5'd0, 16'h0000), 16'h0010);
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL jh_stall: got %0h want 0", bus.stall); end
    tick();
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL jh_halted: got %0h want 0", bus.halted); end
    drive(32'h0, 16'h0011);
    tick();
    checks++; if (bus.ex_pc !== 16'h0010) begin errors++; $display("FAIL jh_pc: got %0h want 10", bus.ex_pc); end
    checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL jh_valid: got %0h want 1", bus.ex_valid); end
  endtask

  task automatic test_halt();
    do_reset();
    for (int a = 0; a < 3; a++) begin
      drive(32'h0, 16'(a + 1));
      tick();
    end
    drive(enc(6'h3F, 5'd0, 5'd0, 16'h0000), 16'h0004);
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL halt_dec_stall: got %0h want 0", bus.stall); end
    tick();
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL halt_bubble: got %0h want 0", bus.ex_valid); end
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_halted: got %0h want 1", bus.halted); end
    for (int k = 0; k < 3; k++) begin
      drive(enc_r(6'h01, 5'd1, 5'd2, 5'd3, 4'h0), 16'h0004);
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL halt_stall[%0d]: got %0h want 1", k, bus.stall); end
      checks++; if (bus.stall_pm !== 1'b1) begin errors++; $display("FAIL halt_stall_pm[%0d]: got %0h want 1", k, bus.stall_pm); end
      tick();
      checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL halt_hold_valid[%0d]: got %0h want 0", k, bus.ex_valid); end
    end
    reset = 1'b0;
    #1;
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_reset_halted: got %0h want 0", bus.halted); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL halt_reset_stall: got %0h want 0", bus.stall); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(32'h0, 16'h0001);
    tick();
    checks++; if (bus.ex_pc !== 16'h0000) begin errors++; $display("FAIL halt_restart_pc: got %0h want 0", bus.ex_pc); end
    checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL halt_restart_valid: got %0h want 1", bus.ex_valid); end
  endtask

  task automatic test_illegal();
    do_reset();
    drive(enc(6'h2A, 5'd7, 5'd7, 16'hFFFF), 16'h0001);
    tick();
    checks++; if (bus.illegal !== 1'b1) begin errors++; $display("FAIL ill_set: got %0h want 1", bus.illegal); end
    checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL ill_valid: got %0h want 1", bus.ex_valid); end
    checks++; if (bus.ex_class !== 3'd0) begin errors++; $display("FAIL ill_class: got %0h want 0", bus.ex_class); end
    checks++; if (bus.ex_reg_write !== 1'b0) begin errors++; $display("FAIL ill_regwr: got %0h want 0", bus.ex_reg_write); end
    drive(enc(6'h03, 5'd5, 5'd1, 16'h0000), 16'h0002);
    tick();
    checks++; if (bus.illegal !== 1'b1) begin errors++; $display("FAIL ill_sticky: got %0h want 1", bus.illegal); end
    drive(enc_r(6'h04, 5'd0, 5'd1, 5'd5, 4'h0), 16'h0003);
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL ill_store_rt_stall: got %0h want 1", bus.stall); end
    #1;
    reset = 1'b0;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL midstall_stall: got %0h want 0", bus.stall); end
    checks++; if (bus.stall_pm !== 1'b0) begin errors++; $display("FAIL midstall_stall_pm: got %0h want 0", bus.stall_pm); end
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL midstall_valid: got %0h want 0", bus.ex_valid); end
    checks++; if (bus.ex_class !== 3'd0) begin errors++; $display("FAIL midstall_class: got %0h want 0", bus.ex_class); end
    checks++; if (bus.ex_pc !== 16'h0) begin errors++; $display("FAIL midstall_pc: got %0h want 0", bus.ex_pc); end
    checks++; if (bus.ex_mem_read !== 1'b0) begin errors++; $display("FAIL midstall_memrd: got %0h want 0", bus.ex_mem_read); end
    checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL midstall_illegal: got %0h want 0", bus.illegal); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(enc_r(6'h01, 5'd6, 5'd5, 5'd2, 4'h0), 16'h0001);
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL post_reset_stall: got %0h want 0", bus.stall); end
    tick();
    checks++; if (bus.ex_pc !== 16'h0000) begin errors++; $display("FAIL post_reset_pc: got %0h want 0", bus.ex_pc); end
  endtask

  initial begin
    checks              = 0;
    errors              = 0;
    reset               = 1'b0;
    bus.ins             = 32'h0;
    bus.current_address = 16'h0;
    test_reset();
    test_stream();
    test_load_use();
    test_jump();
    test_jmp_halt();
    test_halt();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_decode_stage.md
# instruction_decode_stage

Decodes the 32-bit instruction from the program memory stage and registers it into the ID/EX pipeline register for the execute stage. It closes the fetch control loop by driving `stall`, `stall_pm`, `pc_mux_sel` and `jmp_loc` back to program memory. It detects load-use hazards, squashes the wrong-path instruction after a jump, and holds the machine in a halted state after HALT.

## Interface
- Parameters: none. Field widths are fixed by the instruction format.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low; 0 = reset
- `ins`  in  32  instruction from program memory, valid every cycle
- `current_address`  in  16  address program memory is presenting this cycle
- `stall`  out  1  hold program counter (combinational)
- `stall_pm`  out  1  re-present previous instruction (combinational)
- `pc_mux_sel`  out  1  select `jmp_loc` as next fetch address (combinational)
- `jmp_loc`  out  16  jump target (combinational)
- `ex_valid`  out  1  ID/EX holds a real instruction
- `ex_class`  out  3  0 NOP, 1 ALU-R, 2 ALU-I, 3 LOAD, 4 STORE
- `ex_func`  out  4  ALU function, `ins[3:0]`
- `ex_rd`, `ex_rs`, `ex_rt`  out  5 each  register indices
- `ex_imm`  out  16  `ins[15:0]`
- `ex_pc`  out  16  address of the instruction in ID/EX
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`  out  1 each  control bits
- `illegal`  out  1  sticky; set on an undefined opcode
- `halted`  out  1  HALT has retired

## Operation
- Instruction format:
  - opcode `[31:26]`, rd `[25:21]`, rs `[20:16]`, rt `[15:11]`, imm `[15:0]`.
- Opcodes:
  - 00 NOP
  - 01 ALU-R: reads rs, rt; writes rd
  - 02 ALU-I: reads rs; writes rd
  - 03 LOAD: reads rs; writes rd
  - 04 STORE: reads rs, rt
  - 05 JMP: target = imm; no register access
  - 3F HALT
  - Any other opcode: treated as NOP, and `illegal` is set.
- Decode PC: `dec_pc` register loads `current_address` every unstalled cycle. It is the address of the instruction currently on `ins`, because program memory is one-cycle synchronous.
- States:
  - RUN: normal decode.
  - SQUASH: the current `ins` is wrong-path; bubble it, then return to RUN.
  - HALT: absorbing until reset.
- Load-use hazard:
  - Condition: ID/EX is a valid LOAD with `ex_rd != 0`, and the decoding instruction reads register `ex_rd`.
  - Response: `stall = stall_pm = 1` for exactly one cycle, and a bubble is written to ID/EX.
  - `dec_pc` holds during the stall.
- JMP decoded in RUN with no hazard:
  - `pc_mux_sel = 1` and `jmp_loc = imm` in the same cycle.
  - A bubble is written to ID/EX, because JMP has no EX work.
  - Next state is SQUASH.
- SQUASH: `ins` is ignored, even if it is a JMP, LOAD or HALT. A bubble is written and the state returns to RUN.
- HALT decoded in RUN:
  - A bubble is written and the state moves to HALT.
  - In HALT: `stall = stall_pm = 1` continuously, ID/EX receives bubbles, and `halted = 1`.
- A bubble is `ex_valid = 0` with all control bits 0, `ex_class = 0`, and the other fields 0.
- Priority within one cycle: SQUASH > HALT state > load-use hazard > JMP/HALT decode > normal issue.

## Timing
- Latency: an instruction on `ins` in cycle N appears on the `ex_*` outputs after the rising edge ending cycle N.
- `stall`, `stall_pm` and `pc_mux_sel` are Mealy outputs. They are valid in the same cycle as `ins` and must settle before the edge.
- A stalled instruction is re-presented by program memory in cycle N+1 and issues then, provided the hazard is gone (ID/EX now holds a bubble).
- JMP costs 2 dead cycles: the JMP bubble plus the squashed slot.
- Reset asserted (`reset = 0`), taking effect immediately:
  - State RUN, all `ex_*` = 0, `dec_pc` = 0, `illegal` = 0, `halted` = 0.
  - `stall`, `stall_pm`, `pc_mux_sel` = 0 and `jmp_loc` = 0.
- Reset mid-stall or mid-squash discards that condition. The first cycle after release decodes address 0.
- Hazards and jumps involving r0 never stall.

## Test plan
- Reset, then NOP/ALU stream at addresses 0–3: `ex_pc` = 0, 1, 2, 3 on consecutive cycles with `ex_valid = 1`, and `stall` is never asserted.
- LOAD r5 followed by ALU-R r6 = r5 + r2: `stall = stall_pm = 1` for one cycle and one bubble; the ALU issues next with `ex_rs = 5`. Repeating with LOAD r0 gives no stall.
- JMP 0x0040 at address 7: `pc_mux_sel = 1` and `jmp_loc = 0x0040` that cycle; the instruction at 8 is squashed; the next valid `ex_pc` is 0x0040.
- JMP immediately followed by HALT in the shadow slot: HALT is squashed and `halted` stays 0.
- HALT at address 3: a bubble, then `halted = 1` and `stall = stall_pm = 1` indefinitely. Asserting `reset` clears it, and decode restarts at address 0.
- Opcode 0x2A: `illegal = 1` (sticky) with a NOP issued. Asserting `reset` in the middle of a load-use stall clears every output to 0 asynchronously.
